menu_screen_processor: RTL and testbench

- Parametrised successor to the single-screen title processor. It services frame-tick and keyboard interrupts.
- On each frame tick with the GPU ready, it copies one of NUM_PAGES pre-rendered screen pages from RAM into the VRAM window, then pulses GPU_DRAW.
- Keyboard interrupts move a wrapping menu selection up or down. The selection picks the displayed page.
- A configurable select key raises a sticky processor-switch request.

---
 rtl/menu_screen_processor.sv | 247 ++++++++++++++++++++++++
 tb/tb_menu_screen_processor.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_screen_processor.sv
// -----------------------------------------------------------------------------
// menu_screen_processor
//
// Interrupt-driven menu display processor. A frame-tick interrupt copies one
// of NUM_PAGES pre-rendered pages from RAM into the VRAM window, one word at a
// time, and then pulses GPU_DRAW. Key interrupts move a wrapping menu
// selection, and the selection chooses the page shown on the next frame. The
// select key raises a sticky hand-over request and parks the FSM in HOLD.
//
// Ports
//   CLK, RESET      clock, synchronous active-high reset
//   ENABLE          processor active; low forces IDLE and drops the request
//   SWITCH_REQUEST  sticky request to hand control to the next processor
//   SELECTION       current menu index
//   MEM_ENABLE      memory strobe (one cycle per access)
//   MEM_WRITE       1 = write, 0 = read
//   MEM_ADDR        memory address
//   MEM_DATA_R      read data, valid the cycle after a read strobe
//   MEM_DATA_W      write data (word buffer)
//   GPU_READY       GPU can accept a new frame
//   GPU_DRAW        one-cycle draw pulse
//   KBD_KEY         last keyboard scan code
//   INT_IRQ         0 = frame tick, 1 = key event, 2/3 = none
//   INT_IACK        one-cycle interrupt acknowledge
//   INT_IEND        one-cycle end-of-service
// -----------------------------------------------------------------------------
module menu_screen_processor #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] SRC_BASE    = 16'h0800,
  parameter logic [ADDR_W-1:0] PAGE_STRIDE = 16'h0500,
  parameter logic [ADDR_W-1:0] DST_BASE    = 16'hA000,
  parameter int                FRAME_WORDS = 1280,
  parameter int                NUM_PAGES   = 4,
  parameter logic [7:0]        KEY_UP      = 8'h75,
  parameter logic [7:0]        KEY_DOWN    = 8'h72,
  parameter logic [7:0]        KEY_SELECT  = 8'h20,
  localparam int               SEL_W       = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  output logic              SWITCH_REQUEST,
  output logic [SEL_W-1:0]  SELECTION,
  output logic              MEM_ENABLE,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA_R,
  output logic [DATA_W-1:0] MEM_DATA_W,
  input  logic              GPU_READY,
  output logic              GPU_DRAW,
  input  logic [7:0]        KBD_KEY,
  input  logic [1:0]        INT_IRQ,
  output logic              INT_IACK,
  output logic              INT_IEND
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT,
    ST_F_ACK,
    ST_F_CHK,
    ST_RD,
    ST_LATCH,
    ST_WR,
    ST_NEXT,
    ST_DRAW,
    ST_F_END,
    ST_K_ACK,
    ST_K_DEC,
    ST_SW,
    ST_HOLD
  } state_e;

  localparam logic [ADDR_W-1:0] OFF_LAST = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [SEL_W-1:0]  SEL_MAX  = SEL_W'(NUM_PAGES - 1);
  localparam logic [SEL_W-1:0]  SEL_ONE  = SEL_W'(1);
  localparam logic [ADDR_W-1:0] OFF_ONE  = ADDR_W'(1);

  state_e              state_q,  state_d;
  logic [SEL_W-1:0]    sel_q,    sel_d;
  logic [SEL_W-1:0]    page_q,   page_d;
  logic                switch_q, switch_d;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic [DATA_W-1:0]   buffer_q, buffer_d;
  logic [7:0]          key_q,    key_d;

  // Source address of the current word. The page index multiplies a constant
  // stride, so synthesis folds it into a small adder tree; all arithmetic wraps
  // silently at ADDR_W bits.
  logic [ADDR_W-1:0] page_base;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;

  assign page_base = ADDR_W'(page_q) * PAGE_STRIDE;
  assign src_addr  = SRC_BASE + page_base + offset_q;
  assign dst_addr  = DST_BASE + offset_q;

  // ---------------------------------------------------------------------------
  // Next-state logic and Moore output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    page_d     = page_q;
    switch_d   = switch_q;
    offset_d   = offset_q;
    buffer_d   = buffer_q;
    key_d      = key_q;

    MEM_ENABLE = 1'b0;
    MEM_WRITE  = 1'b0;
    MEM_ADDR   = src_addr;
    GPU_DRAW   = 1'b0;
    INT_IACK   = 1'b0;
    INT_IEND   = 1'b0;

    // Outputs depend on the current state only.
    unique case (state_q)
      ST_F_ACK,
      ST_K_ACK: INT_IACK = 1'b1;
      ST_F_END,
      ST_K_DEC: INT_IEND = 1'b1;
      ST_RD:    MEM_ENABLE = 1'b1;
      ST_WR: begin
        MEM_ENABLE = 1'b1;
        MEM_WRITE  = 1'b1;
        MEM_ADDR   = dst_addr;
      end
      ST_DRAW:  GPU_DRAW = 1'b1;
      default: ;
    endcase

    if (!ENABLE) begin
      // Disabling parks the FSM and withdraws the request; the menu index and
      // datapath registers are left as they are.
      state_d  = ST_IDLE;
      switch_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          offset_d = '0;
          state_d  = ST_WAIT;
        end

        ST_WAIT: begin
          case (INT_IRQ)
            2'd0:    state_d = ST_F_ACK;
            2'd1:    state_d = ST_K_ACK;
            default: state_d = ST_WAIT;
          endcase
        end

        // The page is sampled once here, so a key press during a copy only
        // shows up on the following frame.
        ST_F_ACK: begin
          page_d  = sel_q;
          state_d = ST_F_CHK;
        end

        ST_F_CHK: state_d = GPU_READY ? ST_RD : ST_F_END;

        ST_RD:    state_d = ST_LATCH;

        ST_LATCH: begin
          buffer_d = MEM_DATA_R;
          state_d  = ST_WR;
        end

        ST_WR:    state_d = ST_NEXT;

        ST_NEXT: begin
          if (offset_q == OFF_LAST) begin
            offset_d = '0;
            state_d  = ST_DRAW;
          end else begin
            offset_d = offset_q + OFF_ONE;
            state_d  = ST_RD;
          end
        end

        ST_DRAW:  state_d = ST_F_END;

        ST_F_END: state_d = ST_WAIT;

        ST_K_ACK: begin
          key_d   = KBD_KEY;
          state_d = ST_K_DEC;
        end

        ST_K_DEC: begin
          state_d = ST_WAIT;
          if (key_q == KEY_UP) begin
            sel_d = (sel_q == '0) ? SEL_MAX : sel_q - SEL_ONE;
          end else if (key_q == KEY_DOWN) begin
            sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_ONE;
          end else if (key_q == KEY_SELECT) begin
            state_d = ST_SW;
          end
        end

        ST_SW: begin
          switch_d = 1'b1;
          state_d  = ST_HOLD;
        end

        // Interrupts stay pending at the controller; only ENABLE or RESET
        // leaves this state.
        ST_HOLD:  state_d = ST_HOLD;

        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      page_q   <= '0;
      switch_q <= 1'b0;
      offset_q <= '0;
      buffer_q <= '0;
      key_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      page_q   <= page_d;
      switch_q <= switch_d;
      offset_q <= offset_d;
      buffer_q <= buffer_d;
      key_q    <= key_d;
    end
  end

  assign SWITCH_REQUEST = switch_q;
  assign SELECTION      = sel_q;
  assign MEM_DATA_W     = buffer_q;

endmodule

// File: tb/tb_menu_screen_processor.sv
// -----------------------------------------------------------------------------
// tb_menu_screen_processor
//
// Scoreboard bench. Stimulus tasks issue interrupts and push the expected
// strobe events (kind, address, data, absolute cycle) derived from the menu
// rules; a monitor pops and compares every strobe the DUT shows. A small RAM
// responder returns address-derived data for reads.
// -----------------------------------------------------------------------------
module tb_menu_screen_processor;

  localparam int          ADDR_W = 16;
  localparam int          DATA_W = 16;
  localparam int          FW     = 4;
  localparam int          NP     = 4;
  localparam logic [15:0] SRC    = 16'h0800;
  localparam logic [15:0] STRIDE = 16'h0500;
  localparam logic [15:0] DST    = 16'hA000;
  localparam logic [7:0]  K_UP   = 8'h75;
  localparam logic [7:0]  K_DN   = 8'h72;
  localparam logic [7:0]  K_SEL  = 8'h20;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              ENABLE;
  logic              SWITCH_REQUEST;
  logic [1:0]        SELECTION;
  logic              MEM_ENABLE;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_DATA_R;
  logic [DATA_W-1:0] MEM_DATA_W;
  logic              GPU_READY;
  logic              GPU_DRAW;
  logic [7:0]        KBD_KEY;
  logic [1:0]        INT_IRQ;
  logic              INT_IACK;
  logic              INT_IEND;

  menu_screen_processor #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_BASE(SRC), .PAGE_STRIDE(STRIDE),
    .DST_BASE(DST), .FRAME_WORDS(FW), .NUM_PAGES(NP),
    .KEY_UP(K_UP), .KEY_DOWN(K_DN), .KEY_SELECT(K_SEL)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .SWITCH_REQUEST(SWITCH_REQUEST), .SELECTION(SELECTION),
    .MEM_ENABLE(MEM_ENABLE), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
    .MEM_DATA_R(MEM_DATA_R), .MEM_DATA_W(MEM_DATA_W),
    .GPU_READY(GPU_READY), .GPU_DRAW(GPU_DRAW), .KBD_KEY(KBD_KEY),
    .INT_IRQ(INT_IRQ), .INT_IACK(INT_IACK), .INT_IEND(INT_IEND)
  );

  always #5 CLK = ~CLK;

  typedef enum int {EV_ACK, EV_RD, EV_WR, EV_DRAW, EV_END} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          mon_en = 1'b0;
  bit          prev_rd = 1'b0;
  logic [15:0] salt = 16'h1234;
  int          model_sel = 0;
  bit          model_sw  = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return (a * 16'h9E37) ^ salt;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_e k, input logic [15:0] a, input logic [15:0] d, input int c);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // RAM responder: data appears in the read cycle and stays through the next
  // one; at any other time the bus carries noise.
  always @(negedge CLK) begin
    if (MEM_ENABLE && !MEM_WRITE) MEM_DATA_R = mem_f(MEM_ADDR);
    else if (!prev_rd)            MEM_DATA_R = 16'($urandom);
    prev_rd = MEM_ENABLE && !MEM_WRITE;
  end

  // Monitor: every strobe the DUT shows must match the head of the queue.
  always @(negedge CLK) begin
    if (mon_en) begin
      int  ns;
      ev_t o;
      ev_t e;
      ns = int'(MEM_ENABLE) + int'(GPU_DRAW) + int'(INT_IACK) + int'(INT_IEND);
      if (ns > 1) begin
        n_vec++; n_err++;
        $display("FAIL strobes: %0d strobes active at cycle %0d, expected at most 1", ns, cyc);
      end else if (ns == 1) begin
        o.cyc = cyc; o.addr = '0; o.data = '0;
        if (MEM_ENABLE) begin
          o.kind = MEM_WRITE ? EV_WR : EV_RD;
          o.addr = MEM_ADDR;
          if (MEM_WRITE) o.data = MEM_DATA_W;
        end else if (GPU_DRAW) o.kind = EV_DRAW;
        else if (INT_IACK)     o.kind = EV_ACK;
        else                   o.kind = EV_END;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected: event kind=%0d addr=%h at cycle %0d, expected none",
                   int'(o.kind), o.addr, cyc);
        end else begin
          e = exp_q.pop_front();
          n_vec++;
          if (o.kind != e.kind || o.addr != e.addr || o.data != e.data || o.cyc != e.cyc) begin
            n_err++;
            $display("FAIL event: got kind=%0d addr=%h data=%h cyc=%0d, expected kind=%0d addr=%h data=%h cyc=%0d",
                     int'(o.kind), o.addr, o.data, o.cyc, int'(e.kind), e.addr, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [1:0] no_irq();
    return 2'($urandom_range(2, 3));
  endfunction

  task automatic drain();
    int budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) tick();
  endtask

  // Frame interrupt issued while the DUT waits. Schedule from the menu rules:
  // ack, gpu check, then per word read / latch / write / advance, draw, end.
  task automatic frame(input bit ready);
    int          c;
    logic [15:0] src;
    c         = cyc;
    salt      = 16'($urandom);
    GPU_READY = ready;
    INT_IRQ   = 2'd0;
    push(EV_ACK, '0, '0, c + 1);
    if (ready) begin
      for (int k = 0; k < FW; k++) begin
        src = 16'(SRC + 16'(model_sel) * STRIDE + 16'(k));
        push(EV_RD, src, '0, c + 3 + 4 * k);
        push(EV_WR, 16'(DST + 16'(k)), mem_f(src), c + 5 + 4 * k);
      end
      push(EV_DRAW, '0, '0, c + 3 + 4 * FW);
      push(EV_END,  '0, '0, c + 4 + 4 * FW);
    end else begin
      push(EV_END, '0, '0, c + 3);
    end
    tick();
    INT_IRQ = no_irq();
    drain();
  endtask

  task automatic key(input logic [7:0] k);
    int c;
    c       = cyc;
    INT_IRQ = 2'd1;
    KBD_KEY = k;
    push(EV_ACK, '0, '0, c + 1);
    push(EV_END, '0, '0, c + 2);
    if (k == K_UP)       model_sel = (model_sel + NP - 1) % NP;
    else if (k == K_DN)  model_sel = (model_sel + 1) % NP;
    else if (k == K_SEL) model_sw  = 1'b1;
    tick();
    INT_IRQ = no_irq();
    tick();
    KBD_KEY = 8'($urandom);
    drain();
    if (k == K_SEL) tick();
    check("selection", 32'(SELECTION), 32'(model_sel));
    check("switch", 32'(SWITCH_REQUEST), 32'(model_sw));
  endtask

  function automatic logic [7:0] other_key();
    logic [7:0] k;
    do k = 8'($urandom); while (k == K_UP || k == K_DN || k == K_SEL);
    return k;
  endfunction

  task automatic check_quiet(input string name);
    check({name, "_strobes"}, {28'd0, MEM_ENABLE, GPU_DRAW, INT_IACK, INT_IEND}, 32'd0);
  endtask

  initial begin
    int c;
    RESET = 1'b1; ENABLE = 1'b1; GPU_READY = 1'b1; KBD_KEY = 8'h00; INT_IRQ = 2'd2;
    repeat (3) tick();
    check_quiet("reset");
    check("reset_addr", 32'(MEM_ADDR), 32'(SRC));
    check("reset_sel", 32'(SELECTION), 32'd0);
    check("reset_switch", 32'(SWITCH_REQUEST), 32'd0);
    RESET = 1'b0;
    mon_en = 1'b1;
    repeat (2) tick();

    // Directed: plain frame on page 0, skipped frame, selection wrap.
    frame(1'b1);
    frame(1'b0);
    key(K_UP);
    key(K_DN);
    key(K_DN);
    frame(1'b1);
    key(8'h41);
    INT_IRQ = 2'd3;
    repeat (6) tick();
    INT_IRQ = 2'd2;
    repeat (6) tick();
    check("none_irq_sel", 32'(SELECTION), 32'(model_sel));

    // Randomised mix of frames and keys.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    frame(1'b1);
        2:       frame(1'b0);
        3:       key(K_UP);
        4:       key(K_DN);
        default: key(other_key());
      endcase
      repeat ($urandom_range(0, 3)) tick();
    end

    // Select key: sticky request, interrupts ignored, released by ENABLE.
    key(K_SEL);
    INT_IRQ = 2'd0;
    repeat (4) tick();
    INT_IRQ = 2'd1;
    repeat (4) tick();
    INT_IRQ = 2'd3;
    check("hold_switch", 32'(SWITCH_REQUEST), 32'd1);
    check("hold_sel", 32'(SELECTION), 32'(model_sel));
    ENABLE = 1'b0;
    tick();
    model_sw = 1'b0;
    check("disable_switch", 32'(SWITCH_REQUEST), 32'd0);
    check("disable_sel", 32'(SELECTION), 32'(model_sel));
    ENABLE = 1'b1;
    tick();
    frame(1'b1);

    // Reset during the first write of a frame on a non-zero page.
    if (model_sel == 0) key(K_DN);
    c         = cyc;
    salt      = 16'($urandom);
    GPU_READY = 1'b1;
    INT_IRQ   = 2'd0;
    push(EV_ACK, '0, '0, c + 1);
    push(EV_RD, 16'(SRC + 16'(model_sel) * STRIDE), '0, c + 3);
    push(EV_WR, DST, mem_f(16'(SRC + 16'(model_sel) * STRIDE)), c + 5);
    tick();
    INT_IRQ = 2'd2;
    while (cyc < c + 5) tick();
    RESET = 1'b1;
    tick();
    model_sel = 0;
    check_quiet("midreset");
    check("midreset_addr", 32'(MEM_ADDR), 32'(SRC));
    check("midreset_sel", 32'(SELECTION), 32'd0);
    check("midreset_pending", 32'(exp_q.size()), 32'd0);
    RESET = 1'b0;
    repeat (2) tick();
    frame(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
